// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encoding and burst FSM states
// for the universal shift register.
package univ_shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/univ_shift_reg_step_mux.sv
// One-step next-value function shared by the
// single-step and burst paths.
module usr_step_mux
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    unique case (mode)
      MODE_HOLD: q_next = q;
      MODE_SHL:  q_next = {q[WIDTH-2:0], sin_lsb};
      MODE_SHR:  q_next = {sin_msb, q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_LOAD: q_next = d;
      MODE_CLR:  q_next = '0;
      MODE_RSVD: q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step
// operation and a counted burst-shift engine.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       mode_r_q, mode_r_d;
  logic [2:0]       step_mode;
  logic [WIDTH-1:0] q_step;

  // The burst replays the latched mode; idle steps use the live one.
  assign step_mode = (state_q == ST_RUN) ? mode_r_q : mode;

  usr_step_mux #(
    .WIDTH (WIDTH)
  ) u_step (
    .q       (q_q),
    .mode    (step_mode),
    .sin_lsb (sin_lsb),
    .sin_msb (sin_msb),
    .d       (d),
    .q_next  (q_step)
  );

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    rem_d    = rem_q;
    mode_r_d = mode_r_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_r_d = mode;
          rem_d    = cnt;
          state_d  = (cnt != '0) ? ST_RUN : ST_DONE;
        end else if (en) begin
          q_d = q_step;
        end
      end
      ST_RUN: begin
        q_d   = q_step;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      q_q      <= '0;
      rem_q    <= '0;
      mode_r_q <= MODE_HOLD;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      rem_q    <= rem_d;
      mode_r_q <= mode_r_d;
    end
  end

  assign q        = q_q;
  assign sout_msb = q_q[WIDTH-1];
  assign sout_lsb = q_q[0];
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed and randomized checks of univ_shift_reg
// against an arithmetic reference model.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] mode = 3'd0;
  logic       sin_lsb = 1'b0;
  logic       sin_msb = 1'b0;
  logic [7:0] d = 8'd0;
  logic       start = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic [7:0] q;
  logic       sout_msb;
  logic       sout_lsb;
  logic       busy;
  logic       done;

  int   checks = 0;
  int   failures = 0;
  logic [7:0] mq = 8'd0;

  univ_shift_reg #(
    .WIDTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .sin_lsb  (sin_lsb),
    .sin_msb  (sin_msb),
    .d        (d),
    .start    (start),
    .cnt      (cnt),
    .q        (q),
    .sout_msb (sout_msb),
    .sout_lsb (sout_lsb),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mstep(
    input logic [7:0] v, input logic [2:0] m,
    input logic sl, input logic sm, input logic [7:0] dd);
    int x;
    int r;
    x = int'(v);
    case (m)
      3'd1: r = (x * 2 + int'(sl)) % 256;
      3'd2: r = x / 2 + int'(sm) * 128;
      3'd3: r = (x * 2) % 256 + x / 128;
      3'd4: r = x / 2 + (x % 2) * 128;
      3'd5: r = int'(dd);
      3'd6: r = 0;
      default: r = x;
    endcase
    return r[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic eb,
                         input logic ed);
    chk({tag, ".q"}, 32'(q), 32'(mq));
    chk({tag, ".smsb"}, 32'(sout_msb), 32'(mq / 8'd128));
    chk({tag, ".slsb"}, 32'(sout_lsb), 32'(mq % 8'd2));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input string tag, input logic [2:0] m,
                        input logic sl, input logic sm,
                        input logic [7:0] dd);
    en = 1'b1;
    mode = m;
    sin_lsb = sl;
    sin_msb = sm;
    d = dd;
    mq = mstep(mq, m, sl, sm, dd);
    tick();
    en = 1'b0;
    chk_all(tag, 1'b0, 1'b0);
  endtask

  task automatic burst(input string tag, input logic [2:0] m,
                       input int k, input bit rnd_serial,
                       input bit en_at_start);
    mode = m;
    cnt = 4'(k);
    start = 1'b1;
    en = en_at_start;
    d = ~mq;
    tick();
    start = 1'b0;
    chk_all({tag, ".e0"}, k != 0, k == 0);
    for (int i = 1; i <= k; i++) begin
      if (rnd_serial) begin
        sin_lsb = 1'($urandom);
        sin_msb = 1'($urandom);
      end
      d = 8'($urandom);
      en = 1'($urandom);
      mode = 3'($urandom);
      cnt = 4'($urandom);
      start = 1'($urandom);
      mq = mstep(mq, m, sin_lsb, sin_msb, d);
      tick();
      chk_all($sformatf("%s.s%0d", tag, i), i < k, i == k);
    end
    en = 1'($urandom);
    mode = 3'($urandom);
    start = 1'($urandom);
    d = 8'($urandom);
    tick();
    en = 1'b0;
    start = 1'b0;
    chk_all({tag, ".post"}, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] orig;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mq = 8'd0;
    chk_all("rst0", 1'b0, 1'b0);

    single("pre_a5", 3'd5, 1'b0, 1'b0, 8'hA5);
    chk("pre_a5.const", 32'(q), 32'hA5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq = 8'd0;
    chk_all("rst1", 1'b0, 1'b0);

    single("load", 3'd5, 1'b0, 1'b0, 8'h81);
    single("shl", 3'd1, 1'b1, 1'b0, 8'h00);
    chk("shl.const", 32'(q), 32'h03);
    single("shr", 3'd2, 1'b0, 1'b0, 8'h00);
    chk("shr.const", 32'(q), 32'h01);
    single("ror", 3'd4, 1'b0, 1'b0, 8'h00);
    chk("ror.const", 32'(q), 32'h80);
    single("hold", 3'd0, 1'b1, 1'b1, 8'h55);
    single("rsvd", 3'd7, 1'b1, 1'b1, 8'h55);
    en = 1'b0;
    mode = 3'd6;
    tick();
    chk_all("en0", 1'b0, 1'b0);

    single("ld81", 3'd5, 1'b0, 1'b0, 8'h81);
    burst("rol3", 3'd3, 3, 1'b1, 1'b0);
    chk("rol3.const", 32'(q), 32'h0C);

    burst("cnt0", 3'd5, 0, 1'b1, 1'b1);
    chk("cnt0.const", 32'(q), 32'h0C);

    single("clr", 3'd6, 1'b0, 1'b0, 8'h00);
    sin_lsb = 1'b1;
    burst("shl8", 3'd1, 8, 1'b0, 1'b0);
    chk("shl8.const", 32'(q), 32'hFF);
    single("ld_x", 3'd5, 1'b0, 1'b0, 8'h6B);
    orig = mq;
    burst("ror8", 3'd4, 8, 1'b1, 1'b0);
    chk("ror8.orig", 32'(q), 32'(orig));

    mode = 3'd3;
    cnt = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("ab.e0", 1'b1, 1'b0);
    mq = mstep(mq, 3'd3, 1'b0, 1'b0, 8'h00);
    tick();
    chk_all("ab.e1", 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq = 8'd0;
    chk_all("ab.rst", 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_all($sformatf("ab.idle%0d", i), 1'b0, 1'b0);
    end
    single("ab.ld", 3'd5, 1'b0, 1'b0, 8'h3C);
    burst("ab.new", 3'd1, 1, 1'b1, 1'b0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        single($sformatf("r%0d.one", it), 3'($urandom),
               1'($urandom), 1'($urandom), 8'($urandom));
      end else begin
        burst($sformatf("r%0d.bst", it), 3'($urandom),
              int'($urandom_range(0, 15)), 1'b1,
              1'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
